// File: rtl/register_file.sv
// Multi-word register storage: one synchronous write port and two
// combinational read ports, with optional write bypass and zero register.
module register_file #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [ADDR_WIDTH-1:0] read_address_a,
  output logic [WIDTH-1:0]      read_data_a,
  output logic                  valid_a,
  input  logic [ADDR_WIDTH-1:0] read_address_b,
  output logic [WIDTH-1:0]      read_data_b,
  output logic                  valid_b
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;

  logic                  w_in_range;
  logic                  w_wr_ok;
  logic [ADDR_WIDTH-1:0] w_raddr  [2];
  logic [WIDTH-1:0]      w_rdata  [2];
  logic                  w_rvalid [2];

  assign w_in_range = {1'b0, write_address} < LP_DEPTH;

  // A write is dropped entirely when it targets a missing or
  // read-only register; bypass keys off the same qualified strobe.
  assign w_wr_ok = write_enable && w_in_range &&
                   !(ZERO_REG && (write_address == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (write_address == ADDR_WIDTH'(i)) begin
          r_mem[i]   <= write_data;
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  assign w_raddr[0] = read_address_a;
  assign w_raddr[1] = read_address_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      w_rdata[p]  = '0;
      w_rvalid[p] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_raddr[p] == ADDR_WIDTH'(i)) begin
          w_rdata[p]  = r_mem[i];
          w_rvalid[p] = r_valid[i];
        end
      end
      if (BYPASS && !reset && w_wr_ok &&
          (write_address == w_raddr[p])) begin
        w_rdata[p]  = write_data;
        w_rvalid[p] = 1'b1;
      end
      if (ZERO_REG && (w_raddr[p] == '0)) begin
        w_rdata[p]  = '0;
        w_rvalid[p] = 1'b1;
      end
    end
  end

  assign read_data_a = w_rdata[0];
  assign valid_a     = w_rvalid[0];
  assign read_data_b = w_rdata[1];
  assign valid_b     = w_rvalid[1];

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file across four parameter variants
// sharing one stimulus stream.
module tb_register_file;

  typedef struct {
    int         inst;
    string      name;
    logic [7:0] da;
    logic       va;
    logic [7:0] db;
    logic       vb;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       we;
  logic [1:0] wa;
  logic [7:0] wd;
  logic [1:0] ra;
  logic [1:0] rb;

  logic [7:0] rda [4];
  logic [7:0] rdb [4];
  logic       va  [4];
  logic       vb  [4];

  exp_t q[$];
  event ev_sample;
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clock = ~clock;

  // 0: default, 1: no bypass, 2: zero register, 3: depth 3
  register_file #(.WIDTH(8), .DEPTH(4)) u0 (
    .clock(clock), .reset(reset), .write_enable(we),
    .write_address(wa), .write_data(wd),
    .read_address_a(ra), .read_data_a(rda[0]), .valid_a(va[0]),
    .read_address_b(rb), .read_data_b(rdb[0]), .valid_b(vb[0]));

  register_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1'b0)) u1 (
    .clock(clock), .reset(reset), .write_enable(we),
    .write_address(wa), .write_data(wd),
    .read_address_a(ra), .read_data_a(rda[1]), .valid_a(va[1]),
    .read_address_b(rb), .read_data_b(rdb[1]), .valid_b(vb[1]));

  register_file #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1'b1)) u2 (
    .clock(clock), .reset(reset), .write_enable(we),
    .write_address(wa), .write_data(wd),
    .read_address_a(ra), .read_data_a(rda[2]), .valid_a(va[2]),
    .read_address_b(rb), .read_data_b(rdb[2]), .valid_b(vb[2]));

  register_file #(.WIDTH(8), .DEPTH(3)) u3 (
    .clock(clock), .reset(reset), .write_enable(we),
    .write_address(wa), .write_data(wd),
    .read_address_a(ra), .read_data_a(rda[3]), .valid_a(va[3]),
    .read_address_b(rb), .read_data_b(rdb[3]), .valid_b(vb[3]));

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_sample);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (rda[e.inst] !== e.da || va[e.inst] !== e.va ||
            rdb[e.inst] !== e.db || vb[e.inst] !== e.vb) begin
          n_err++;
          $display("FAIL %s u%0d: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b",
                   e.name, e.inst, rda[e.inst], va[e.inst],
                   rdb[e.inst], vb[e.inst], e.da, e.va, e.db, e.vb);
        end
      end
    end
  end

  task automatic expect_rd(input int inst, input string name,
                           input logic [7:0] da, input logic a_v,
                           input logic [7:0] db, input logic b_v);
    exp_t e;
    e.inst = inst; e.name = name;
    e.da = da; e.va = a_v; e.db = db; e.vb = b_v;
    q.push_back(e);
  endtask

  task automatic sample();
    -> ev_sample;
    #2;
    if (q.size() > 0) begin
      n_err++;
      n_chk++;
      $display("FAIL monitor_timeout: got %0d pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic wr_edge(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock);
    we = 1'b1; wa = a; wd = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = 2'd2; rb = 2'd0;
    #2;
    for (int i = 0; i < 4; i++) begin
      expect_rd(i, "reset", 8'h00, 1'b0, 8'h00, i == 2);
    end
    sample();
    @(negedge clock);
    reset = 1'b0;

    // write A5 to 2; pre-edge bypass vs stored
    @(negedge clock);
    we = 1'b1; wa = 2'd2; wd = 8'hA5; ra = 2'd2; rb = 2'd1;
    #1;
    expect_rd(0, "byp_a5", 8'hA5, 1'b1, 8'h00, 1'b0);
    expect_rd(1, "nobyp_a5", 8'h00, 1'b0, 8'h00, 1'b0);
    expect_rd(3, "d3_byp_a5", 8'hA5, 1'b1, 8'h00, 1'b0);
    sample();
    @(posedge clock);
    #1;
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_rd(i, "wr_a5", 8'hA5, 1'b1, 8'h00, 1'b0);
    end
    sample();

    // write 3C to 3; depth-3 variant must ignore it
    @(negedge clock);
    we = 1'b1; wa = 2'd3; wd = 8'h3C; ra = 2'd3; rb = 2'd3;
    #1;
    expect_rd(0, "byp_3c", 8'h3C, 1'b1, 8'h3C, 1'b1);
    expect_rd(1, "nobyp_3c_pre", 8'h00, 1'b0, 8'h00, 1'b0);
    expect_rd(3, "d3_oor_byp", 8'h00, 1'b0, 8'h00, 1'b0);
    sample();
    @(posedge clock);
    #1;
    we = 1'b0;
    expect_rd(0, "wr_3c", 8'h3C, 1'b1, 8'h3C, 1'b1);
    expect_rd(1, "nobyp_3c_post", 8'h3C, 1'b1, 8'h3C, 1'b1);
    expect_rd(3, "d3_oor_wr", 8'h00, 1'b0, 8'h00, 1'b0);
    sample();

    // write FF to 0; zero register stays 0
    @(negedge clock);
    we = 1'b1; wa = 2'd0; wd = 8'hFF; ra = 2'd0; rb = 2'd2;
    #1;
    expect_rd(2, "zr_byp", 8'h00, 1'b1, 8'hA5, 1'b1);
    expect_rd(0, "byp_ff", 8'hFF, 1'b1, 8'hA5, 1'b1);
    sample();
    @(posedge clock);
    #1;
    we = 1'b0;
    expect_rd(2, "zr_wr", 8'h00, 1'b1, 8'hA5, 1'b1);
    expect_rd(1, "wr_ff", 8'hFF, 1'b1, 8'hA5, 1'b1);
    sample();

    ra = 2'd1; rb = 2'd1;
    wr_edge(2'd1, 8'h11);
    expect_rd(2, "zr_wr11", 8'h11, 1'b1, 8'h11, 1'b1);
    sample();

    wr_edge(2'd1, 8'h9C);
    for (int i = 0; i < 4; i++) begin
      expect_rd(i, "dual_9c", 8'h9C, 1'b1, 8'h9C, 1'b1);
    end
    sample();

    // back-to-back writes with enable held across two edges
    @(negedge clock);
    we = 1'b1; wa = 2'd1; wd = 8'h01;
    @(negedge clock);
    wd = 8'h02;
    @(posedge clock);
    #1;
    we = 1'b0;
    expect_rd(1, "b2b", 8'h02, 1'b1, 8'h02, 1'b1);
    sample();

    ra = 2'd0; rb = 2'd2;
    #1;
    expect_rd(3, "d3_keep", 8'hFF, 1'b1, 8'hA5, 1'b1);
    sample();

    wr_edge(2'd0, 8'h12);
    wr_edge(2'd1, 8'h34);
    wr_edge(2'd2, 8'h56);
    wr_edge(2'd3, 8'h78);
    ra = 2'd0; rb = 2'd3;
    #1;
    expect_rd(0, "load", 8'h12, 1'b1, 8'h78, 1'b1);
    expect_rd(2, "zr_load", 8'h00, 1'b1, 8'h78, 1'b1);
    sample();

    // asynchronous reset between edges
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    expect_rd(0, "async_rst", 8'h00, 1'b0, 8'h00, 1'b0);
    expect_rd(2, "zr_async_rst", 8'h00, 1'b1, 8'h00, 1'b0);
    sample();

    we = 1'b1; wa = 2'd1; wd = 8'hAA; ra = 2'd1; rb = 2'd3;
    #1;
    expect_rd(0, "rst_no_byp", 8'h00, 1'b0, 8'h00, 1'b0);
    sample();
    @(posedge clock);
    #1;
    expect_rd(0, "rst_wins", 8'h00, 1'b0, 8'h00, 1'b0);
    sample();

    @(negedge clock);
    we = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    expect_rd(0, "post_rst", 8'h00, 1'b0, 8'h00, 1'b0);
    expect_rd(1, "post_rst_nb", 8'h00, 1'b0, 8'h00, 1'b0);
    sample();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
